// File: rtl/network_div_pkg.sv
// Shared widths, FSM state encoding and quotient saturation helper for the
// network's sequential signed divider.
package network_div_pkg;

    localparam int DIVIDEND_WIDTH = 30;
    localparam int DIVISOR_WIDTH  = 16;
    localparam int QUOT_WIDTH     = 16;
    localparam int REM_WIDTH      = DIVISOR_WIDTH + 1;
    localparam int CNT_WIDTH      = 5;

    // FSM encoding kept as plain constants for compatibility with older flows.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DIV  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [QUOT_WIDTH-1:0] QMAX = 16'h7FFF;  //  32767
    localparam logic [QUOT_WIDTH-1:0] QMIN = 16'h8000;  // -32768

    // Largest quotient magnitudes that still fit for each sign.
    localparam logic [DIVIDEND_WIDTH-1:0] POS_LIMIT = 30'd32767;
    localparam logic [DIVIDEND_WIDTH-1:0] NEG_LIMIT = 30'd32768;

    typedef struct packed {
        logic [QUOT_WIDTH-1:0] quot;
        logic                  ovf;
    } sat_t;

    // Apply the sign to an unsigned quotient magnitude and clamp to 16 bits.
    function automatic sat_t saturate(input logic neg,
                                      input logic [DIVIDEND_WIDTH-1:0] mag);
        sat_t r;
        r.ovf  = 1'b0;
        r.quot = QUOT_WIDTH'(mag);
        if (neg) begin
            r.quot = QUOT_WIDTH'(-mag);
            if (mag > NEG_LIMIT) begin
                r.quot = QMIN;
                r.ovf  = 1'b1;
            end
        end else if (mag > POS_LIMIT) begin
            r.quot = QMAX;
            r.ovf  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/network_sdiv_30s_16s_16_seq_core.sv
// Unsigned radix-2 restoring division datapath: partial remainder, quotient
// shift register (initially holding the dividend) and iteration counter.
module network_sdiv_30s_16s_16_seq_core
    import network_div_pkg::*;
(
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      load,
    input  logic                      step,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_mag,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_mag,
    output logic [DIVIDEND_WIDTH-1:0] quot_mag,
    output logic [DIVISOR_WIDTH-1:0]  rem_mag,
    output logic                      last
);

    logic [REM_WIDTH-1:0]      prem_q, prem_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [DIVISOR_WIDTH-1:0]  dvs_q, dvs_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [REM_WIDTH:0]        shifted;
    logic                      fits;

    // One restoring iteration: shift in the next dividend bit, trial-subtract.
    always_comb begin
        // NOTE: every _d gets its default first so no path leaves it unassigned (no latch).
        prem_d  = prem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        shifted = {prem_q, quo_q[DIVIDEND_WIDTH-1]};
        fits    = shifted >= {2'b00, dvs_q};
        if (load) begin
            prem_d = '0;
            quo_d  = dividend_mag;
            dvs_d  = divisor_mag;
            cnt_d  = CNT_WIDTH'(DIVIDEND_WIDTH - 1);
        end else if (step) begin
            if (fits) begin
                prem_d = REM_WIDTH'(shifted - {2'b00, dvs_q});
            end else begin
                prem_d = REM_WIDTH'(shifted);
            end
            quo_d = {quo_q[DIVIDEND_WIDTH-2:0], fits};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        // NOTE: datapath registers are reset as well, so an aborted division leaves no stale operands.
        if (!ap_rst_n) begin
            prem_q <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking (<=) so every flop samples pre-edge values.
            prem_q <= prem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign quot_mag = quo_q;
    assign rem_mag  = prem_q[DIVISOR_WIDTH-1:0];
    assign last     = (cnt_q == '0);

endmodule

// File: rtl/network_sdiv_30s_16s_16_seq.sv
// Sequential 30s / 16s signed divider with saturated 16-bit quotient.
// Handles operand signs, saturation, divide-by-zero and valid/ready handshake;
// the unsigned iteration lives in the core.
module network_sdiv_30s_16s_16_seq
    import network_div_pkg::*;
(
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOT_WIDTH-1:0]     quotient,
    output logic [QUOT_WIDTH-1:0]     remainder,
    output logic                      ovf,
    output logic                      dbz
);

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic                  dbz_flag_q, dbz_flag_d;
    logic                  out_valid_q, out_valid_d;
    logic [QUOT_WIDTH-1:0] quotient_q, quotient_d;
    logic [QUOT_WIDTH-1:0] remainder_q, remainder_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;

    logic                      accept;
    logic [DIVIDEND_WIDTH-1:0] dividend_mag;
    logic [DIVISOR_WIDTH-1:0]  divisor_mag;
    logic [DIVIDEND_WIDTH-1:0] core_quot;
    logic [DIVISOR_WIDTH-1:0]  core_rem;
    logic                      core_last;
    sat_t                      sat;

    // Operand magnitudes; unsigned widths cover -2^29 and -32768 exactly.
    assign accept       = in_valid & in_ready_q;
    assign dividend_mag = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[DIVISOR_WIDTH-1]  ? -divisor  : divisor;

    network_sdiv_30s_16s_16_seq_core u_core (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .load         (accept),
        .step         (state_q == ST_DIV),
        .dividend_mag (dividend_mag),
        .divisor_mag  (divisor_mag),
        .quot_mag     (core_quot),
        .rem_mag      (core_rem),
        .last         (core_last)
    );

    // Handshake FSM plus sign fix-up and saturation of the final result.
    always_comb begin
        state_d     = state_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        dbz_flag_d  = dbz_flag_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        // Ready rises one cycle after entering IDLE, never in the accept cycle.
        in_ready_d  = (state_q == ST_IDLE) & ~accept;
        sat         = saturate(sign_a_q ^ sign_b_q, core_quot);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sign_a_d   = dividend[DIVIDEND_WIDTH-1];
                    sign_b_d   = divisor[DIVISOR_WIDTH-1];
                    dbz_flag_d = (divisor == '0);
                    state_d    = (divisor == '0) ? ST_FIX : ST_DIV;
                end
            end
            ST_DIV: begin
                if (core_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
                if (dbz_flag_q) begin
                    quotient_d  = sign_a_q ? QMIN : QMAX;
                    remainder_d = '0;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = sat.quot;
                    remainder_d = sign_a_q ? -core_rem : core_rem;
                    ovf_d       = sat.ovf;
                    dbz_d       = 1'b0;
                end
            end
            default: begin  // ST_DONE
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            dbz_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            dbz_flag_q  <= dbz_flag_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule
